// File: rtl/keypad_if.sv
// Signals between the keypad scanner and a 4x4 contact matrix.
// The master side is the scanner; the slave side is the matrix (or a bench model).
interface keypad_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_strobe;

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_pressed,
    output key_strobe
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_pressed,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per scan tick, debounces
// press and release over DEBOUNCE_TICKS ticks and reports row*4+col.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_LIM  = 8'(DEBOUNCE_TICKS);

  logic [3:0]  col_p0, col_p1;
  logic [15:0] div_cnt;
  logic        tick;

  state_t      state, state_nxt;
  logic [1:0]  row_idx, row_nxt;
  logic [1:0]  cand_col, cand_nxt;
  logic [7:0]  stab_cnt, stab_nxt, stab_inc;
  logic [3:0]  code, code_nxt;
  logic        pressed, pressed_nxt;
  logic        strobe, strobe_nxt;
  logic        cand_low, stab_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_p0 <= 4'b1111;
      col_p1 <= 4'b1111;
    end else begin
      col_p0 <= kp.col_in;
      col_p1 <= col_p0;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= 16'd0;
    else       div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
  end

  assign cand_low  = ~col_p1[cand_col];
  assign stab_inc  = sat_inc(stab_cnt);
  assign stab_done = (stab_inc >= DEB_LIM);

  always_comb begin
    state_nxt   = state;
    row_nxt     = row_idx;
    cand_nxt    = cand_col;
    stab_nxt    = stab_cnt;
    code_nxt    = code;
    pressed_nxt = pressed;
    strobe_nxt  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (col_p1 != 4'b1111) begin
            cand_nxt  = lowest_low(col_p1);
            stab_nxt  = 8'd0;
            state_nxt = DEBOUNCE;
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            stab_nxt = stab_inc;
            if (stab_done) begin
              state_nxt   = HELD;
              code_nxt    = {row_idx, cand_col};
              pressed_nxt = 1'b1;
              strobe_nxt  = 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            row_nxt   = row_idx + 2'd1;
          end
        end
        HELD: begin
          if (!cand_low) begin
            stab_nxt  = 8'd0;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            stab_nxt = stab_inc;
            if (stab_done) begin
              pressed_nxt = 1'b0;
              state_nxt   = SCAN;
              row_nxt     = row_idx + 2'd1;
            end
          end else begin
            // Bounce during release: the key is still considered held
            stab_nxt  = 8'd0;
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SCAN;
      row_idx  <= 2'd0;
      cand_col <= 2'd0;
      stab_cnt <= 8'd0;
      code     <= 4'd0;
      pressed  <= 1'b0;
      strobe   <= 1'b0;
    end else begin
      state    <= state_nxt;
      row_idx  <= row_nxt;
      cand_col <= cand_nxt;
      stab_cnt <= stab_nxt;
      code     <= code_nxt;
      pressed  <= pressed_nxt;
      strobe   <= strobe_nxt;
    end
  end

  assign kp.row_out     = ~(4'b0001 << row_idx);
  assign kp.key_code    = code;
  assign kp.key_pressed = pressed;
  assign kp.key_strobe  = strobe;

endmodule
